input_conditioner: RTL and testbench

//  Front-end stage upstream of the multiplier top level. Conditions the raw board pushbuttons (KEY_n, active-low,

---
 rtl/mult_io_pkg.sv | 17 +
 rtl/debounce_bit.sv | 82 ++++++++
 rtl/input_conditioner.sv | 50 +++++
 tb/tb_input_conditioner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_io_pkg.sv
// Shared constants for the multiplier I/O front end: key indices and default sizing.
// Port summary: none (package only).
// Optional feature macro used by the conditioner: INPUT_COND_RELEASE_PULSE_EN.
package mult_io_pkg;

  localparam int KEY_RLC                 = 0;       // Reset_Load_Clear pushbutton
  localparam int KEY_RUN                 = 1;       // Run pushbutton
  localparam int NUM_KEYS_DEFAULT        = 2;
  localparam int SW_WIDTH_DEFAULT        = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz

  // Counter width for a debounce window; never collapses to zero bits.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Debounces one active-low asynchronous pushbutton: 2-flop sync, stability counter, level and edge pulses.
// Ports: clk_i, rst_ni (async active-low), key_n_i (raw, 0 = pressed) -> level_o, press_o, release_o.
// release_o only pulses when INPUT_COND_RELEASE_PULSE_EN is defined; otherwise it is tied to 0.
module debounce_bit
  import mult_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          sample;

  // Debouncer works in "pressed = 1" polarity.
  assign sample = ~sync2_q;

  // Count consecutive cycles that disagree with the accepted state; any agreeing
  // cycle restarts the window, so bounces shorter than the window are absorbed.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sample;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign press_d = stable_d & ~stable_q;

  // Sync flops reset to "released" so a key held through reset is seen as a new press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

`ifdef INPUT_COND_RELEASE_PULSE_EN
  logic release_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      release_q <= 1'b0;
    end else begin
      release_q <= stable_q & ~stable_d;
    end
  end

  assign release_o = release_q;
`else
  assign release_o = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Front end for the multiplier: debounced key levels, one-cycle press/release pulses, synchronized switches.
// Ports: Clk, Reset_n (async active-low), KEY_n[NUM_KEYS], SW_Raw[SW_WIDTH] -> Key_Level, Key_Press, Key_Release, SW_Sync.
// Key_Release pulses only with INPUT_COND_RELEASE_PULSE_EN defined. Hookup: Reset_Load_Clear = Key_Level[KEY_RLC], Run = Key_Press[KEY_RUN].
module input_conditioner
  import mult_io_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int SW_WIDTH        = SW_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] KEY_n,
  input  logic [SW_WIDTH-1:0] SW_Raw,
  output logic [NUM_KEYS-1:0] Key_Level,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [SW_WIDTH-1:0] SW_Sync
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .key_n_i  (KEY_n[g]),
      .level_o  (Key_Level[g]),
      .press_o  (Key_Press[g]),
      .release_o(Key_Release[g])
    );
  end

  // Switches are only sampled by the multiplier on Run/Load, so a plain
  // two-flop synchronizer without debounce is sufficient.
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW_Raw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign SW_Sync = sw_sync_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int NK = 2;
  localparam int SW = 8;
  localparam int D  = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [NK-1:0] KEY_n;
  logic [SW-1:0] SW_Raw;
  logic [NK-1:0] Key_Level, Key_Press, Key_Release;
  logic [SW-1:0] SW_Sync;

  input_conditioner #(
    .NUM_KEYS(NK), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .KEY_n(KEY_n), .SW_Raw(SW_Raw),
    .Key_Level(Key_Level), .Key_Press(Key_Press), .Key_Release(Key_Release), .SW_Sync(SW_Sync)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples travel through a two-deep pipeline, then a key's
  // accepted state flips once the last D seen samples all disagree with it.
  bit            raw_q [NK][$];
  bit            win_q [NK][$];
  bit   [SW-1:0] sw_q[$];
  logic [NK-1:0] exp_lvl, exp_press, exp_rel;
  logic [SW-1:0] exp_sw;

  int p0, p1, both;

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      raw_q[k].delete();
      raw_q[k].push_back(1'b0);
      raw_q[k].push_back(1'b0);
      win_q[k].delete();
    end
    sw_q.delete();
    sw_q.push_back('0);
    exp_lvl   = '0;
    exp_press = '0;
    exp_rel   = '0;
    exp_sw    = '0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      bit seen;
      bit all_diff;
      raw_q[k].push_back(!KEY_n[k]);
      seen = raw_q[k].pop_front();
      win_q[k].push_back(seen);
      if (win_q[k].size() > D) void'(win_q[k].pop_front());
      exp_press[k] = 1'b0;
      exp_rel[k]   = 1'b0;
      all_diff = (win_q[k].size() == D);
      for (int i = 0; i < win_q[k].size(); i++)
        if (win_q[k][i] == exp_lvl[k]) all_diff = 1'b0;
      if (all_diff) begin
        exp_lvl[k] = ~exp_lvl[k];
        if (exp_lvl[k]) exp_press[k] = 1'b1;
        else            exp_rel[k]   = 1'b1;
        win_q[k].delete();
      end
    end
    sw_q.push_back(SW_Raw);
    exp_sw = sw_q.pop_front();
  endtask

  task automatic tick();
    logic [NK-1:0] rel_exp;
    @(posedge Clk);
    if (!Reset_n) model_reset();
    else          model_edge();
    #1;
`ifdef INPUT_COND_RELEASE_PULSE_EN
    rel_exp = exp_rel;
`else
    rel_exp = '0;
`endif
    check_val("key_level",   32'(Key_Level),   32'(exp_lvl));
    check_val("key_press",   32'(Key_Press),   32'(exp_press));
    check_val("key_release", 32'(Key_Release), 32'(rel_exp));
    check_val("sw_sync",     32'(SW_Sync),     32'(exp_sw));
    if (Key_Press[0]) p0++;
    if (Key_Press[1]) p1++;
    if (Key_Press == 2'b11) both++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    p0 = 0; p1 = 0; both = 0;
  endtask

  initial begin
    // 1: keys held through reset, accepted as fresh presses afterwards
    Reset_n = 1'b0;
    KEY_n   = 2'b00;
    SW_Raw  = '0;
    model_reset();
    clr_counts();
    #1;
    check_val("rst_level", 32'(Key_Level), 32'h0);
    check_val("rst_sw",    32'(SW_Sync),   32'h0);
    ticks(3);
    Reset_n = 1'b1;
    ticks(10);
    check_val("held_rst_p0", p0, 1);
    check_val("held_rst_p1", p1, 1);
    check_val("held_rst_lvl", 32'(Key_Level), 32'h3);

    // 2: clean press of Run
    KEY_n = 2'b11;
    ticks(10);
    clr_counts();
    KEY_n[1] = 1'b0;
    ticks(20);
    check_val("clean_p1", p1, 1);
    check_val("clean_p0", p0, 0);

    // 3: bouncing Run, then held
    KEY_n = 2'b11;
    ticks(10);
    clr_counts();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) KEY_n[1] = ~KEY_n[1];
      tick();
    end
    KEY_n[1] = 1'b0;
    ticks(15);
    check_val("bounce_p1", p1, 1);

    // 4: release after press
    KEY_n[1] = 1'b1;
    ticks(12);
    check_val("release_lvl", 32'(Key_Level), 32'h0);

    // 5: reset while Run is mid-count and Reset_Load_Clear is accepted
    KEY_n[0] = 1'b0;
    ticks(10);
    KEY_n[1] = 1'b0;
    ticks(5);
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("async_rst_lvl",   32'(Key_Level), 32'h0);
    check_val("async_rst_press", 32'(Key_Press), 32'h0);
    model_reset();
    KEY_n = 2'b11;
    ticks(2);
    Reset_n = 1'b1;
    clr_counts();
    ticks(15);
    check_val("rst_no_p0", p0, 0);
    check_val("rst_no_p1", p1, 0);

    // 6: simultaneous presses, switch bus step
    SW_Raw = 8'h00;
    ticks(3);
    clr_counts();
    KEY_n  = 2'b00;
    SW_Raw = 8'hA5;
    tick();
    check_val("sw_one_edge", 32'(SW_Sync), 32'h00);
    tick();
    check_val("sw_two_edge", 32'(SW_Sync), 32'hA5);
    ticks(8);
    check_val("both_press", both, 1);
    KEY_n = 2'b11;
    ticks(10);

    // Random: keys change rarely enough to produce both accepted holds and glitches
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) KEY_n[0] = ~KEY_n[0];
      if ($urandom_range(7) == 0) KEY_n[1] = ~KEY_n[1];
      if ($urandom_range(3) == 0) SW_Raw = SW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
